reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 107 ++++++++++
 tb/tb_reservation_station.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: ENTRIES-deep operand-capturing reservation station feeding one ALU.
// Ports: clk/rst (async active-low); op_in/value*_in/query*_in/target_in issue one op;
// alu_num/alu_value and mem_num/mem_value are result broadcasts (tag 0 = none);
// rs_full flags all entries busy; alu_op/alu_v1/alu_v2/alu_dest carry the registered dispatch.
module reservation_station #(
  parameter int          ENTRIES = 4,
  parameter logic [4:0]  NOP_OP  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [2:0]  target_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        rs_full,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_v1,
  output logic [31:0] alu_v2,
  output logic [2:0]  alu_dest
);
  localparam int IW = $clog2(ENTRIES);
  logic [ENTRIES-1:0] busy_q, busy_d, ready;
  logic [4:0]  op_q [ENTRIES], op_d [ENTRIES];
  logic [31:0] v1_q [ENTRIES], v1_d [ENTRIES], v2_q [ENTRIES], v2_d [ENTRIES];
  logic [2:0]  q1_q [ENTRIES], q1_d [ENTRIES], q2_q [ENTRIES], q2_d [ENTRIES];
  logic [2:0]  dest_q [ENTRIES], dest_d [ENTRIES];
  logic          disp_vld, ins_vld;
  logic [IW-1:0] disp_idx, ins_idx;
  logic [4:0]  alu_op_d;
  logic [31:0] alu_v1_d, alu_v2_d;
  logic [2:0]  alu_dest_d;
  // Resolve one operand against the broadcasts: ALU wins over memory, tag 0 never matches.
  function automatic logic [34:0] resolve(input logic [2:0] q, input logic [31:0] v);
    return (q != 3'd0 && q == alu_num) ? {3'd0, alu_value} :
           (q != 3'd0 && q == mem_num) ? {3'd0, mem_value} : {q, v};
  endfunction
  assign rs_full = &busy_q;
  always_comb begin
    disp_vld = 1'b0;
    disp_idx = '0;
    ins_vld  = 1'b0;
    ins_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && q1_q[i] == 3'd0 && q2_q[i] == 3'd0;
      if (ready[i]) begin
        disp_vld = 1'b1;
        disp_idx = IW'(i);
      end
      if (!busy_q[i]) begin
        ins_vld = op_in != NOP_OP;
        ins_idx = IW'(i);
      end
    end
  end
  // Insert targets a slot free before the edge, so a slot freed by this edge's dispatch stays idle.
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    dest_d = dest_q;
    for (int i = 0; i < ENTRIES; i++) begin
      {q1_d[i], v1_d[i]} = resolve(q1_q[i], v1_q[i]);
      {q2_d[i], v2_d[i]} = resolve(q2_q[i], v2_q[i]);
    end
    if (disp_vld) busy_d[disp_idx] = 1'b0;
    if (ins_vld) begin
      busy_d[ins_idx] = 1'b1;
      op_d[ins_idx]   = op_in;
      dest_d[ins_idx] = target_in;
      {q1_d[ins_idx], v1_d[ins_idx]} = resolve(query1_in, value1_in);
      {q2_d[ins_idx], v2_d[ins_idx]} = resolve(query2_in, value2_in);
    end
    alu_op_d   = disp_vld ? op_q[disp_idx]   : NOP_OP;
    alu_dest_d = disp_vld ? dest_q[disp_idx] : 3'd0;
    alu_v1_d   = disp_vld ? v1_q[disp_idx]   : alu_v1;
    alu_v2_d   = disp_vld ? v2_q[disp_idx]   : alu_v2;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      alu_op   <= NOP_OP;
      alu_v1   <= '0;
      alu_v2   <= '0;
      alu_dest <= '0;
    end else begin
      busy_q   <= busy_d;
      alu_op   <= alu_op_d;
      alu_v1   <= alu_v1_d;
      alu_v2   <= alu_v2_d;
      alu_dest <= alu_dest_d;
    end
  end
  // Payload is qualified by busy, so it carries no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    q1_q   <= q1_d;
    q2_q   <= q2_d;
    dest_q <= dest_d;
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed self-checking bench for reservation_station.
module tb_reservation_station;
  localparam logic [4:0] NOP = 5'b11111;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  op_in = NOP;
  logic [31:0] value1_in = '0, value2_in = '0, alu_value = '0, mem_value = '0;
  logic [2:0]  query1_in = '0, query2_in = '0, target_in = '0, alu_num = '0, mem_num = '0;
  logic        rs_full;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;
  logic [2:0]  alu_dest;
  int checks = 0;
  int passes = 0;
  reservation_station #(.ENTRIES(4), .NOP_OP(NOP)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in), .target_in(target_in),
    .alu_num(alu_num), .alu_value(alu_value), .mem_num(mem_num), .mem_value(mem_value),
    .rs_full(rs_full), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_dest(alu_dest)
  );
  always #5 clk = ~clk;
  task automatic idle();
    op_in = NOP; value1_in = '0; value2_in = '0; query1_in = '0; query2_in = '0;
    target_in = '0; alu_num = '0; alu_value = '0; mem_num = '0; mem_value = '0;
  endtask
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [2:0] qa,
                       input logic [31:0] b, input logic [2:0] qb, input logic [2:0] t);
    op_in = op; value1_in = a; query1_in = qa; value2_in = b; query2_in = qb; target_in = t;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (rs_full !== 1'b0) $display("FAIL reset_full: got %0b exp 0", rs_full); else passes++;
    checks++; if (alu_op !== NOP) $display("FAIL reset_op: got %0h exp %0h", alu_op, NOP); else passes++;
    checks++; if (alu_dest !== 3'd0) $display("FAIL reset_dest: got %0d exp 0", alu_dest); else passes++;
    checks++; if (alu_v1 !== 32'd0 || alu_v2 !== 32'd0) $display("FAIL reset_vals: got %0h/%0h exp 0/0", alu_v1, alu_v2); else passes++;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask
  task automatic test_ready_issue();
    drive(5'd0, 32'd5, 3'd0, 32'd7, 3'd0, 3'd3);
    tick();
    idle();
    checks++; if (alu_op !== NOP) $display("FAIL ready_early: got %0h exp %0h", alu_op, NOP); else passes++;
    tick();
    checks++; if (alu_op !== 5'd0) $display("FAIL ready_op: got %0h exp 0", alu_op); else passes++;
    checks++; if (alu_v1 !== 32'd5 || alu_v2 !== 32'd7) $display("FAIL ready_vals: got %0h/%0h exp 5/7", alu_v1, alu_v2); else passes++;
    checks++; if (alu_dest !== 3'd3) $display("FAIL ready_dest: got %0d exp 3", alu_dest); else passes++;
    tick();
    checks++; if (alu_op !== NOP || alu_dest !== 3'd0) $display("FAIL ready_idle: got %0h/%0d exp %0h/0", alu_op, alu_dest, NOP); else passes++;
    checks++; if (alu_v1 !== 32'd5 || alu_v2 !== 32'd7) $display("FAIL ready_hold: got %0h/%0h exp 5/7", alu_v1, alu_v2); else passes++;
  endtask
  task automatic test_wakeup();
    drive(5'd1, 32'd0, 3'd2, 32'd1, 3'd0, 3'd4);
    tick();
    idle();
    tick();
    checks++; if (alu_op !== NOP) $display("FAIL wake_wait: got %0h exp %0h", alu_op, NOP); else passes++;
    alu_num = 3'd2; alu_value = 32'h10;
    tick();
    idle();
    checks++; if (alu_op !== NOP) $display("FAIL wake_latency: got %0h exp %0h", alu_op, NOP); else passes++;
    tick();
    checks++; if (alu_op !== 5'd1 || alu_dest !== 3'd4) $display("FAIL wake_disp: got %0h/%0d exp 1/4", alu_op, alu_dest); else passes++;
    checks++; if (alu_v1 !== 32'h10 || alu_v2 !== 32'd1) $display("FAIL wake_vals: got %0h/%0h exp 10/1", alu_v1, alu_v2); else passes++;
  endtask
  task automatic test_forward();
    drive(5'd2, 32'd3, 3'd0, 32'd0, 3'd5, 3'd5);
    mem_num = 3'd5; mem_value = 32'hABCD;
    tick();
    idle();
    tick();
    checks++; if (alu_op !== 5'd2 || alu_dest !== 3'd5) $display("FAIL fwd_disp: got %0h/%0d exp 2/5", alu_op, alu_dest); else passes++;
    checks++; if (alu_v1 !== 32'd3 || alu_v2 !== 32'hABCD) $display("FAIL fwd_vals: got %0h/%0h exp 3/abcd", alu_v1, alu_v2); else passes++;
    tick();
  endtask
  task automatic test_back_to_back();
    drive(5'd3, 32'd11, 3'd0, 32'd12, 3'd0, 3'd1);
    tick();
    drive(5'd4, 32'd21, 3'd0, 32'd22, 3'd0, 3'd2);
    tick();
    idle();
    checks++; if (alu_op !== 5'd3 || alu_v1 !== 32'd11 || alu_dest !== 3'd1) $display("FAIL b2b_first: got %0h/%0h/%0d exp 3/b/1", alu_op, alu_v1, alu_dest); else passes++;
    tick();
    checks++; if (alu_op !== 5'd4 || alu_v2 !== 32'd22 || alu_dest !== 3'd2) $display("FAIL b2b_second: got %0h/%0h/%0d exp 4/16/2", alu_op, alu_v2, alu_dest); else passes++;
    tick();
    checks++; if (alu_op !== NOP) $display("FAIL b2b_idle: got %0h exp %0h", alu_op, NOP); else passes++;
  endtask
  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      drive(5'(8 + k), 32'd0, 3'd6, 32'(k), 3'd0, 3'(k + 1));
      tick();
    end
    checks++; if (rs_full !== 1'b1) $display("FAIL full_set: got %0b exp 1", rs_full); else passes++;
    drive(5'd12, 32'd1, 3'd0, 32'd2, 3'd0, 3'd7);
    tick();
    idle();
    checks++; if (rs_full !== 1'b1 || alu_op !== NOP) $display("FAIL full_drop: got %0b/%0h exp 1/%0h", rs_full, alu_op, NOP); else passes++;
    mem_num = 3'd6; mem_value = 32'h60;
    tick();
    idle();
    checks++; if (rs_full !== 1'b1 || alu_op !== NOP) $display("FAIL full_wake: got %0b/%0h exp 1/%0h", rs_full, alu_op, NOP); else passes++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (alu_op !== 5'(8 + k) || alu_dest !== 3'(k + 1) || alu_v1 !== 32'h60 || alu_v2 !== 32'(k))
        $display("FAIL full_disp%0d: got %0h/%0d/%0h/%0h exp %0h/%0d/60/%0h", k, alu_op, alu_dest, alu_v1, alu_v2, 8 + k, k + 1, k);
      else passes++;
      checks++; if (rs_full !== 1'b0) $display("FAIL full_clear%0d: got %0b exp 0", k, rs_full); else passes++;
    end
    tick();
    checks++; if (alu_op !== NOP) $display("FAIL full_dropped_gone: got %0h exp %0h", alu_op, NOP); else passes++;
  endtask
  task automatic test_priority();
    drive(5'd13, 32'd0, 3'd1, 32'd2, 3'd0, 3'd6);
    tick();
    idle();
    alu_num = 3'd1; alu_value = 32'd9; mem_num = 3'd1; mem_value = 32'd8;
    tick();
    idle();
    tick();
    checks++; if (alu_op !== 5'd13 || alu_v1 !== 32'd9 || alu_dest !== 3'd6) $display("FAIL prio: got %0h/%0h/%0d exp d/9/6", alu_op, alu_v1, alu_dest); else passes++;
    tick();
  endtask
  task automatic test_async_reset();
    drive(5'd1, 32'd0, 3'd7, 32'd0, 3'd0, 3'd1);
    tick();
    drive(5'd2, 32'd0, 3'd7, 32'd0, 3'd0, 3'd2);
    tick();
    drive(5'd14, 32'd4, 3'd0, 32'd5, 3'd0, 3'd7);
    tick();
    drive(5'd3, 32'd0, 3'd7, 32'd0, 3'd0, 3'd3);
    tick();
    idle();
    checks++; if (alu_op !== 5'd14 || alu_dest !== 3'd7) $display("FAIL ares_pre: got %0h/%0d exp e/7", alu_op, alu_dest); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (rs_full !== 1'b0 || alu_op !== NOP || alu_dest !== 3'd0) $display("FAIL ares_now: got %0b/%0h/%0d exp 0/%0h/0", rs_full, alu_op, alu_dest, NOP); else passes++;
    checks++; if (alu_v1 !== 32'd0 || alu_v2 !== 32'd0) $display("FAIL ares_vals: got %0h/%0h exp 0/0", alu_v1, alu_v2); else passes++;
    drive(5'd15, 32'd1, 3'd0, 32'd1, 3'd0, 3'd5);
    tick();
    @(negedge clk);
    idle();
    rst = 1'b1;
    alu_num = 3'd7; alu_value = 32'h77;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (alu_op !== NOP || alu_dest !== 3'd0) $display("FAIL ares_quiet%0d: got %0h/%0d exp %0h/0", k, alu_op, alu_dest, NOP); else passes++;
      tick();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_forward();
    test_back_to_back();
    test_full();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
